// File: rtl/axil_master_adaptor.sv
// Single-beat request/response to AXI4-Lite master bridge, one transaction in flight.
// Define AXIL_MASTER_ALIGN_CHECK_EN to reject misaligned/oversized requests with an error response.
module axil_master_adaptor #(
  parameter int unsigned axil_data_width_p = 32,
  parameter int unsigned axil_addr_width_p = 32
) (
  input  logic                               clk_i,
  input  logic                               reset_i,

  input  logic                               v_i,
  output logic                               ready_and_o,
  input  logic [axil_addr_width_p-1:0]       addr_i,
  input  logic                               wr_en_i,
  input  logic [1:0]                         data_size_i,
  input  logic [axil_data_width_p-1:0]       wdata_i,

  output logic                               v_o,
  input  logic                               ready_and_i,
  output logic [axil_data_width_p-1:0]       rdata_o,
  output logic                               err_o,

  output logic [axil_addr_width_p-1:0]       m_axil_awaddr_o,
  output logic [2:0]                         m_axil_awprot_o,
  output logic                               m_axil_awvalid_o,
  input  logic                               m_axil_awready_i,

  output logic [axil_data_width_p-1:0]       m_axil_wdata_o,
  output logic [axil_data_width_p/8-1:0]     m_axil_wstrb_o,
  output logic                               m_axil_wvalid_o,
  input  logic                               m_axil_wready_i,

  input  logic [1:0]                         m_axil_bresp_i,
  input  logic                               m_axil_bvalid_i,
  output logic                               m_axil_bready_o,

  output logic [axil_addr_width_p-1:0]       m_axil_araddr_o,
  output logic [2:0]                         m_axil_arprot_o,
  output logic                               m_axil_arvalid_o,
  input  logic                               m_axil_arready_i,

  input  logic [axil_data_width_p-1:0]       m_axil_rdata_i,
  input  logic [1:0]                         m_axil_rresp_i,
  input  logic                               m_axil_rvalid_i,
  output logic                               m_axil_rready_o
);

  localparam int unsigned StrbW = axil_data_width_p / 8;
  localparam int unsigned LgW   = $clog2(StrbW);
  localparam int unsigned StrbExtW = 16;

  typedef enum logic [2:0] {
    E_IDLE,
    E_WR,
    E_WAIT_B,
    E_RD,
    E_WAIT_R,
    E_RESP
  } state_e;

  state_e                          state_q;
  logic                            ready_q;
  logic                            v_q;
  logic                            err_q;
  logic [axil_data_width_p-1:0]    rdata_q;
  logic [axil_addr_width_p-1:0]    addr_q;
  logic [1:0]                      size_q;
  logic [axil_data_width_p-1:0]    wdata_q;
  logic [StrbW-1:0]                strb_q;
  logic                            awvalid_q;
  logic                            wvalid_q;
  logic                            bready_q;
  logic                            arvalid_q;
  logic                            rready_q;

  // Request-side lane arithmetic, evaluated on the incoming request
  logic [3:0]                      req_bytes;
  logic [2:0]                      size_mask;
  logic [2:0]                      lane_idx;
  logic [StrbExtW-1:0]             strb_ext;
  logic [StrbW-1:0]                req_strb;
  logic [axil_data_width_p-1:0]    req_wdata;

  always_comb begin
    req_bytes = 4'(4'd1 << data_size_i);
    size_mask = 3'(req_bytes - 4'd1);
    strb_ext  = StrbExtW'((StrbExtW'(1) << req_bytes) - StrbExtW'(1));
    strb_ext  = StrbExtW'(strb_ext << addr_i[LgW-1:0]);
    req_strb  = strb_ext[StrbW-1:0];
    req_wdata = '0;
    lane_idx  = '0;
    for (int b = 0; b < int'(StrbW); b++) begin
      lane_idx = 3'(b) & size_mask;
      req_wdata[b*8 +: 8] = 8'(wdata_i >> {lane_idx, 3'b000});
    end
  end

`ifdef AXIL_MASTER_ALIGN_CHECK_EN
  logic req_bad;
  always_comb begin
    req_bad = ((addr_i[2:0] & size_mask) != 3'd0) || (32'(data_size_i) > LgW);
  end
`endif

  // Response-side extraction from the registered offset and size
  logic [3:0]                      rd_bytes;
  logic [axil_data_width_p-1:0]    rd_shift;
  logic [axil_data_width_p-1:0]    rd_extract;

  always_comb begin
    rd_bytes   = 4'(4'd1 << size_q);
    rd_shift   = m_axil_rdata_i >> {addr_q[LgW-1:0], 3'b000};
    rd_extract = '0;
    for (int b = 0; b < int'(StrbW); b++) begin
      rd_extract[b*8 +: 8] = (4'(b) < rd_bytes) ? rd_shift[b*8 +: 8] : 8'h00;
    end
  end

  logic aw_done;
  logic w_done;
  assign aw_done = !awvalid_q || m_axil_awready_i;
  assign w_done  = !wvalid_q  || m_axil_wready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= E_IDLE;
      ready_q   <= 1'b0;
      v_q       <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      case (state_q)
        E_IDLE: begin
          ready_q <= 1'b1;
          if (v_i && ready_q) begin
            ready_q <= 1'b0;
            addr_q  <= addr_i;
            size_q  <= data_size_i;
            wdata_q <= req_wdata;
            strb_q  <= req_strb;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef AXIL_MASTER_ALIGN_CHECK_EN
            if (req_bad) begin
              v_q     <= 1'b1;
              err_q   <= 1'b1;
              state_q <= E_RESP;
            end else
`endif
            if (wr_en_i) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= E_WR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= E_RD;
            end
          end
        end
        // AW and W retire independently; move on once both have handshaken
        E_WR: begin
          if (awvalid_q && m_axil_awready_i) awvalid_q <= 1'b0;
          if (wvalid_q && m_axil_wready_i)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= E_WAIT_B;
          end
        end
        E_WAIT_B: begin
          if (m_axil_bvalid_i) begin
            bready_q <= 1'b0;
            err_q    <= m_axil_bresp_i[1];
            rdata_q  <= '0;
            v_q      <= 1'b1;
            state_q  <= E_RESP;
          end
        end
        E_RD: begin
          if (m_axil_arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= E_WAIT_R;
          end
        end
        E_WAIT_R: begin
          if (m_axil_rvalid_i) begin
            rready_q <= 1'b0;
            rdata_q  <= rd_extract;
            err_q    <= m_axil_rresp_i[1];
            v_q      <= 1'b1;
            state_q  <= E_RESP;
          end
        end
        E_RESP: begin
          if (ready_and_i) begin
            v_q     <= 1'b0;
            ready_q <= 1'b1;
            state_q <= E_IDLE;
          end
        end
        default: state_q <= E_IDLE;
      endcase
    end
  end

  // Only the SLVERR/DECERR bit of each response is meaningful here
  logic unused_resp_lsb;
  assign unused_resp_lsb = m_axil_bresp_i[0] ^ m_axil_rresp_i[0];

  assign ready_and_o      = ready_q;
  assign v_o              = v_q;
  assign rdata_o          = rdata_q;
  assign err_o            = err_q;

  assign m_axil_awaddr_o  = addr_q;
  assign m_axil_awprot_o  = 3'b000;
  assign m_axil_awvalid_o = awvalid_q;
  assign m_axil_wdata_o   = wdata_q;
  assign m_axil_wstrb_o   = strb_q;
  assign m_axil_wvalid_o  = wvalid_q;
  assign m_axil_bready_o  = bready_q;
  assign m_axil_araddr_o  = addr_q;
  assign m_axil_arprot_o  = 3'b000;
  assign m_axil_arvalid_o = arvalid_q;
  assign m_axil_rready_o  = rready_q;

endmodule

// File: tb/tb_axil_master_adaptor.sv
// Directed bench for axil_master_adaptor on a 32-bit bus with a scripted AXI4-Lite slave.
module tb_axil_master_adaptor;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic        ready_and_o;
  logic [31:0] addr_i;
  logic        wr_en_i;
  logic [1:0]  data_size_i;
  logic [31:0] wdata_i;
  logic        v_o;
  logic        ready_and_i;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int vectors = 0;
  int miscompares = 0;
  int b_hs = 0;
  int resp_cnt = 0;
  int b_base;
  int r_base;

  axil_master_adaptor #(.axil_data_width_p(32), .axil_addr_width_p(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .v_i(v_i), .ready_and_o(ready_and_o), .addr_i(addr_i), .wr_en_i(wr_en_i),
    .data_size_i(data_size_i), .wdata_i(wdata_i),
    .v_o(v_o), .ready_and_i(ready_and_i), .rdata_o(rdata_o), .err_o(err_o),
    .m_axil_awaddr_o(awaddr), .m_axil_awprot_o(awprot), .m_axil_awvalid_o(awvalid),
    .m_axil_awready_i(awready),
    .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb), .m_axil_wvalid_o(wvalid),
    .m_axil_wready_i(wready),
    .m_axil_bresp_i(bresp), .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready),
    .m_axil_araddr_o(araddr), .m_axil_arprot_o(arprot), .m_axil_arvalid_o(arvalid),
    .m_axil_arready_i(arready),
    .m_axil_rdata_i(rdata), .m_axil_rresp_i(rresp), .m_axil_rvalid_i(rvalid),
    .m_axil_rready_o(rready)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (bvalid && bready) b_hs++;
    if (v_o && ready_and_i) resp_cnt++;
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    vectors++;
    if ({ready_and_o, v_o, awvalid, wvalid, arvalid, bready, rready, err_o} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {ready_and_o, v_o, awvalid, wvalid, arvalid, bready, rready, err_o});
    end
    vectors++;
    if (rdata_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h want 00000000", rdata_o);
    end
    reset_i = 1'b0;
    tick();
    vectors++;
    if (ready_and_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_rise: got %b want 1", ready_and_o);
    end
  endtask

  task automatic test_write_word();
    v_i = 1'b1; wr_en_i = 1'b1; addr_i = 32'h40; data_size_i = 2'd2; wdata_i = 32'hAABBCCDD;
    awready = 1'b1; wready = 1'b1; bresp = 2'b00;
    vectors++;
    if (ready_and_o !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_accept_ready: got %b want 1", ready_and_o);
    end
    tick();
    v_i = 1'b0;
    vectors++;
    if ({awvalid, wvalid, wstrb} !== 6'b11_1111 || awaddr !== 32'h40 || awprot !== 3'b000) begin
      miscompares++;
      $display("FAIL wr_c1_aw_w: got aw=%b w=%b strb=%h addr=%h prot=%b want 1 1 f 00000040 000",
               awvalid, wvalid, wstrb, awaddr, awprot);
    end
    vectors++;
    if (wdata !== 32'hAABBCCDD) begin
      miscompares++;
      $display("FAIL wr_c1_wdata: got %h want aabbccdd", wdata);
    end
    bvalid = 1'b1;
    tick();
    vectors++;
    if ({bready, awvalid, wvalid} !== 3'b100) begin
      miscompares++;
      $display("FAIL wr_c2_bready: got %b want 100", {bready, awvalid, wvalid});
    end
    tick();
    bvalid = 1'b0;
    vectors++;
    if ({v_o, err_o, ready_and_o} !== 3'b100 || rdata_o !== 32'h0) begin
      miscompares++;
      $display("FAIL wr_c3_resp: got v=%b err=%b rdy=%b rdata=%h want 1 0 0 00000000",
               v_o, err_o, ready_and_o, rdata_o);
    end
    tick();
    vectors++;
    if ({v_o, ready_and_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL wr_c4_idle: got v=%b rdy=%b want 0 1", v_o, ready_and_o);
    end
  endtask

  task automatic test_byte_write();
    v_i = 1'b1; wr_en_i = 1'b1; addr_i = 32'h43; data_size_i = 2'd0; wdata_i = 32'h1234565A;
    awready = 1'b1; wready = 1'b1;
    tick();
    v_i = 1'b0;
    vectors++;
    if (wdata !== 32'h5A5A5A5A || wstrb !== 4'h8 || awaddr !== 32'h43) begin
      miscompares++;
      $display("FAIL bw_lanes: got wdata=%h strb=%h addr=%h want 5a5a5a5a 8 00000043",
               wdata, wstrb, awaddr);
    end
    bvalid = 1'b1;
    repeat (2) tick();
    bvalid = 1'b0;
    vectors++;
    if ({v_o, err_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL bw_resp: got v=%b err=%b want 1 0", v_o, err_o);
    end
    tick();
  endtask

  task automatic test_byte_read();
    v_i = 1'b1; wr_en_i = 1'b0; addr_i = 32'h42; data_size_i = 2'd0; arready = 1'b1;
    tick();
    v_i = 1'b0;
    vectors++;
    if ({arvalid, awvalid, wvalid} !== 3'b100 || araddr !== 32'h42 || arprot !== 3'b000) begin
      miscompares++;
      $display("FAIL br_c1_ar: got ar=%b aw=%b w=%b addr=%h prot=%b want 1 0 0 00000042 000",
               arvalid, awvalid, wvalid, araddr, arprot);
    end
    rvalid = 1'b1; rdata = 32'h11223344; rresp = 2'b00;
    tick();
    vectors++;
    if ({rready, arvalid} !== 2'b10) begin
      miscompares++;
      $display("FAIL br_c2_rready: got %b want 10", {rready, arvalid});
    end
    tick();
    rvalid = 1'b0;
    vectors++;
    if (v_o !== 1'b1 || rdata_o !== 32'h00000022 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL br_c3_data: got v=%b rdata=%h err=%b want 1 00000022 0", v_o, rdata_o, err_o);
    end
    tick();
  endtask

  task automatic test_aw_stall();
    b_base = b_hs; r_base = resp_cnt;
    v_i = 1'b1; wr_en_i = 1'b1; addr_i = 32'h80; data_size_i = 2'd2; wdata_i = 32'hCAFEF00D;
    awready = 1'b0; wready = 1'b1;
    tick();
    v_i = 1'b0; addr_i = 32'hFFFF_FFFC;
    vectors++;
    if ({awvalid, wvalid} !== 2'b11) begin
      miscompares++;
      $display("FAIL st_c1_valids: got %b want 11", {awvalid, wvalid});
    end
    for (int k = 2; k <= 5; k++) begin
      tick();
      vectors++;
      if ({awvalid, wvalid, bready} !== 3'b100 || awaddr !== 32'h80) begin
        miscompares++;
        $display("FAIL st_hold_c%0d: got aw=%b w=%b bready=%b addr=%h want 1 0 0 00000080",
                 k, awvalid, wvalid, bready, awaddr);
      end
    end
    awready = 1'b1;
    bvalid = 1'b1;
    tick();
    awready = 1'b0;
    vectors++;
    if ({awvalid, bready} !== 2'b01) begin
      miscompares++;
      $display("FAIL st_c6_waitb: got aw=%b bready=%b want 0 1", awvalid, bready);
    end
    tick();
    vectors++;
    if ({v_o, bready} !== 2'b10) begin
      miscompares++;
      $display("FAIL st_c7_resp: got v=%b bready=%b want 1 0", v_o, bready);
    end
    tick();
    bvalid = 1'b0;
    vectors++;
    if ((b_hs - b_base) !== 1 || (resp_cnt - r_base) !== 1 || v_o !== 1'b0) begin
      miscompares++;
      $display("FAIL st_counts: got b=%0d resp=%0d v=%b want 1 1 0",
               b_hs - b_base, resp_cnt - r_base, v_o);
    end
  endtask

  task automatic test_read_err_stall();
    ready_and_i = 1'b0;
    v_i = 1'b1; wr_en_i = 1'b0; addr_i = 32'h10; data_size_i = 2'd2; arready = 1'b1;
    tick();
    v_i = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b10;
    tick();
    tick();
    rvalid = 1'b0; rdata = 32'h0;
    for (int k = 3; k <= 5; k++) begin
      vectors++;
      if ({v_o, err_o, ready_and_o} !== 3'b110 || rdata_o !== 32'hDEADBEEF) begin
        miscompares++;
        $display("FAIL re_hold_c%0d: got v=%b err=%b rdy=%b rdata=%h want 1 1 0 deadbeef",
                 k, v_o, err_o, ready_and_o, rdata_o);
      end
      tick();
    end
    vectors++;
    if ({v_o, ready_and_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL re_c6_consume: got v=%b rdy=%b want 1 0", v_o, ready_and_o);
    end
    ready_and_i = 1'b1;
    tick();
    vectors++;
    if ({v_o, ready_and_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL re_c7_idle: got v=%b rdy=%b want 0 1", v_o, ready_and_o);
    end
  endtask

  task automatic test_misaligned();
`ifdef AXIL_MASTER_ALIGN_CHECK_EN
    v_i = 1'b1; wr_en_i = 1'b1; addr_i = 32'h41; data_size_i = 2'd1; wdata_i = 32'hBEEF;
    awready = 1'b1; wready = 1'b1;
    tick();
    v_i = 1'b0;
    vectors++;
    if ({awvalid, wvalid, arvalid} !== 3'b000 || {v_o, err_o} !== 2'b11 || rdata_o !== 32'h0) begin
      miscompares++;
      $display("FAIL mis_err: got aw=%b w=%b ar=%b v=%b err=%b rdata=%h want 0 0 0 1 1 00000000",
               awvalid, wvalid, arvalid, v_o, err_o, rdata_o);
    end
    tick();
    vectors++;
    if ({v_o, ready_and_o, awvalid, wvalid} !== 4'b0100) begin
      miscompares++;
      $display("FAIL mis_idle: got %b want 0100", {v_o, ready_and_o, awvalid, wvalid});
    end
`else
    v_i = 1'b1; wr_en_i = 1'b1; addr_i = 32'h43; data_size_i = 2'd1; wdata_i = 32'h0000BEEF;
    awready = 1'b1; wready = 1'b1;
    tick();
    v_i = 1'b0;
    vectors++;
    if (wdata !== 32'hBEEFBEEF || wstrb !== 4'h8 || awvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL mis_trunc: got wdata=%h strb=%h aw=%b want beefbeef 8 1", wdata, wstrb, awvalid);
    end
    bvalid = 1'b1;
    repeat (2) tick();
    bvalid = 1'b0;
    vectors++;
    if ({v_o, err_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL mis_resp: got v=%b err=%b want 1 0", v_o, err_o);
    end
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    v_i = 1'b1; wr_en_i = 1'b0; addr_i = 32'h20; data_size_i = 2'd2; arready = 1'b1;
    tick();
    v_i = 1'b0;
    tick();
    vectors++;
    if (rready !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_waitr: got rready=%b want 1", rready);
    end
    reset_i = 1'b1;
    #1;
    vectors++;
    if ({ready_and_o, v_o, awvalid, wvalid, arvalid, bready, rready, err_o} !== 8'h00 ||
        rdata_o !== 32'h0) begin
      miscompares++;
      $display("FAIL rm_abort: got ctrl=%b rdata=%h want 00000000 00000000",
               {ready_and_o, v_o, awvalid, wvalid, arvalid, bready, rready, err_o}, rdata_o);
    end
    tick();
    reset_i = 1'b0;
    tick();
    vectors++;
    if ({ready_and_o, rready, v_o} !== 3'b100) begin
      miscompares++;
      $display("FAIL rm_recover: got %b want 100", {ready_and_o, rready, v_o});
    end
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; addr_i = '0; wr_en_i = 1'b0; data_size_i = '0; wdata_i = '0;
    ready_and_i = 1'b1; awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
    arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
    test_reset();
    test_write_word();
    test_byte_write();
    test_byte_read();
    test_aw_stall();
    test_read_err_stall();
    test_misaligned();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
